// File: rtl/seq_detect_arbiter.sv
// Round-robin arbiter that shares one serial "10101" Mealy detector between two word requesters.
// Optional OVERLAP_EN: after a match the detector resumes from "101", so matches may overlap.
module seq_detect_arbiter #(
  parameter int W     = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [W-1:0]     req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [W-1:0]     req1_data,
  output logic             req1_ready,
  output logic             busy,
  output logic             done_valid,
  output logic             done_id,
  output logic [CNT_W-1:0] done_count
);

  localparam int BW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } ctrl_e;

  typedef enum logic [2:0] {
    D0,
    D1,
    D2,
    D3,
    D4
  } det_e;

`ifdef OVERLAP_EN
  localparam det_e MATCH_NEXT = D3;
`else
  localparam det_e MATCH_NEXT = D1;
`endif

  ctrl_e            state_q, state_d;
  det_e             det_q, det_d, det_next;
  logic [W-1:0]     shift_q, shift_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             last_grant_q, last_grant_d;
  logic             done_id_q, done_id_d;
  logic [CNT_W-1:0] done_count_q, done_count_d;

  logic sel0, sel1;
  logic det_in;
  logic match;

  // On a tie the requester that did not win last time is selected.
  always_comb begin
    sel0       = req0_valid && (!req1_valid || last_grant_q);
    sel1       = req1_valid && (!req0_valid || !last_grant_q);
    req0_ready = (state_q == ST_IDLE) && sel0;
    req1_ready = (state_q == ST_IDLE) && sel1;
  end

  always_comb begin
    det_in   = shift_q[W-1];
    match    = 1'b0;
    det_next = D0;
    case (det_q)
      D0: det_next = det_in ? D1 : D0;
      D1: det_next = det_in ? D1 : D2;
      D2: det_next = det_in ? D3 : D0;
      D3: det_next = det_in ? D1 : D4;
      D4: begin
        if (det_in) begin
          match    = 1'b1;
          det_next = MATCH_NEXT;
        end else begin
          det_next = D0;
        end
      end
      default: det_next = D0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    det_d        = det_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    count_d      = count_q;
    last_grant_d = last_grant_q;
    done_id_d    = done_id_q;
    done_count_d = done_count_q;
    case (state_q)
      ST_IDLE: begin
        if (req0_ready || req1_ready) begin
          shift_d      = req0_ready ? req0_data : req1_data;
          last_grant_d = req1_ready;
          det_d        = D0;
          count_d      = '0;
          bit_cnt_d    = BW'(W - 1);
          state_d      = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        det_d   = det_next;
        shift_d = {shift_q[W-2:0], 1'b0};
        if (match && (count_q != CNT_MAX)) begin
          count_d = count_q + CNT_W'(1);
        end
        // The result registers capture the count including the final bit's match.
        if (bit_cnt_q == '0) begin
          state_d      = ST_DONE;
          done_count_d = count_d;
          done_id_d    = last_grant_q;
        end else begin
          bit_cnt_d = bit_cnt_q - BW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      det_q        <= D0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      count_q      <= '0;
      last_grant_q <= 1'b1;
      done_id_q    <= 1'b0;
      done_count_q <= '0;
    end else begin
      state_q      <= state_d;
      det_q        <= det_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      count_q      <= count_d;
      last_grant_q <= last_grant_d;
      done_id_q    <= done_id_d;
      done_count_q <= done_count_d;
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign done_valid = (state_q == ST_DONE);
  assign done_id    = done_id_q;
  assign done_count = done_count_q;

endmodule

// File: tb/tb_seq_detect_arbiter.sv
// Directed self-checking bench for seq_detect_arbiter (8-bit instance plus a 16-bit/2-bit-count instance).
module tb_seq_detect_arbiter;

  localparam int W     = 8;
  localparam int CNT_W = 4;
  localparam int W16   = 16;
  localparam int CNT16 = 2;

`ifdef OVERLAP_EN
  localparam int EXP_AA = 2;
  localparam int EXP_55 = 2;
`else
  localparam int EXP_AA = 1;
  localparam int EXP_55 = 1;
`endif
  localparam int EXP_WIDE = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req0_valid = 1'b0;
  logic [W-1:0]     req0_data = '0;
  logic             req0_ready;
  logic             req1_valid = 1'b0;
  logic [W-1:0]     req1_data = '0;
  logic             req1_ready;
  logic             busy;
  logic             done_valid;
  logic             done_id;
  logic [CNT_W-1:0] done_count;

  logic             w_valid = 1'b0;
  logic [W16-1:0]   w_data = '0;
  logic             w_ready;
  logic             w1_valid = 1'b0;
  logic [W16-1:0]   w1_data = '0;
  logic             w1_ready;
  logic             w_busy;
  logic             w_done_valid;
  logic             w_done_id;
  logic [CNT16-1:0] w_done_count;

  int checks = 0;
  int errors = 0;

  seq_detect_arbiter #(.W(W), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .busy(busy), .done_valid(done_valid), .done_id(done_id), .done_count(done_count)
  );

  seq_detect_arbiter #(.W(W16), .CNT_W(CNT16)) u_dut16 (
    .clk(clk), .rst(rst),
    .req0_valid(w_valid), .req0_data(w_data), .req0_ready(w_ready),
    .req1_valid(w1_valid), .req1_data(w1_data), .req1_ready(w1_ready),
    .busy(w_busy), .done_valid(w_done_valid), .done_id(w_done_id), .done_count(w_done_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    w_valid    = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Submits one word on the chosen port (0,1 = 8-bit dut, 2 = 16-bit dut) and waits for its result.
  task automatic submit(input int which, input logic [15:0] data, output logic rdy,
                        output int lat, output int cnt, output int id);
    case (which)
      0: begin req0_data = data[W-1:0]; req0_valid = 1'b1; end
      1: begin req1_data = data[W-1:0]; req1_valid = 1'b1; end
      default: begin w_data = data; w_valid = 1'b1; end
    endcase
    #1;
    rdy = (which == 0) ? req0_ready : (which == 1) ? req1_ready : w_ready;
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    w_valid    = 1'b0;
    lat = -1;
    cnt = -1;
    id  = -1;
    for (int k = 1; k < 40; k++) begin
      if ((which == 2) ? w_done_valid : done_valid) begin
        lat = k;
        cnt = (which == 2) ? int'(w_done_count) : int'(done_count);
        id  = (which == 2) ? int'(w_done_id) : int'(done_id);
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++;
    if (done_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_done_valid: got %b expected 0", done_valid); end
    checks++;
    if (done_id !== 1'b0) begin errors++; $display("[TB] FAIL reset_done_id: got %b expected 0", done_id); end
    checks++;
    if (done_count !== '0) begin errors++; $display("[TB] FAIL reset_done_count: got %0d expected 0", done_count); end
    checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 00", {req0_ready, req1_ready}); end
    do_reset();
  endtask

  task automatic test_single_word();
    int lat;
    req0_data  = 8'hA8;
    req0_valid = 1'b1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("[TB] FAIL single_ready: got %b expected 10", {req0_ready, req1_ready}); end
    tick();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy_t1: got %b expected 1", busy); end
    checks++;
    if (req0_ready !== 1'b0) begin errors++; $display("[TB] FAIL single_ready_in_shift: got %b expected 0", req0_ready); end
    req0_valid = 1'b0;
    lat = -1;
    for (int k = 1; k < 40; k++) begin
      if (done_valid) begin lat = k; break; end
      tick();
    end
    checks++;
    if (lat != W + 1) begin errors++; $display("[TB] FAIL single_latency: got %0d expected %0d", lat, W + 1); end
    checks++;
    if (done_id !== 1'b0) begin errors++; $display("[TB] FAIL single_done_id: got %b expected 0", done_id); end
    checks++;
    if (done_count !== CNT_W'(1)) begin errors++; $display("[TB] FAIL single_done_count: got %0d expected 1", done_count); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy_done: got %b expected 1", busy); end
    tick();
    checks++;
    if ({busy, done_valid} !== 2'b00) begin errors++; $display("[TB] FAIL single_after_done: got busy/done %b expected 00", {busy, done_valid}); end
    checks++;
    if (done_count !== CNT_W'(1)) begin errors++; $display("[TB] FAIL single_count_hold: got %0d expected 1", done_count); end
  endtask

  task automatic test_words();
    logic [7:0] words [5] = '{8'hAA, 8'h55, 8'hB5, 8'hA5, 8'h95};
    int         ports [5] = '{1, 0, 1, 0, 1};
    int         exps  [5] = '{EXP_AA, EXP_55, 1, 0, 1};
    logic rdy;
    int lat, cnt, id;
    for (int i = 0; i < 5; i++) begin
      submit(ports[i], {8'h00, words[i]}, rdy, lat, cnt, id);
      checks++;
      if (rdy !== 1'b1) begin errors++; $display("[TB] FAIL words_ready[%0d]: got %b expected 1", i, rdy); end
      checks++;
      if (lat != W + 1) begin errors++; $display("[TB] FAIL words_latency[%0d]: got %0d expected %0d", i, lat, W + 1); end
      checks++;
      if (id != ports[i]) begin errors++; $display("[TB] FAIL words_id[%0d]: got %0d expected %0d", i, id, ports[i]); end
      checks++;
      if (cnt != exps[i]) begin errors++; $display("[TB] FAIL words_count[%0d] word %h: got %0d expected %0d", i, words[i], cnt, exps[i]); end
      tick();
    end
  endtask

  task automatic test_reset_abort();
    logic rdy;
    int lat, cnt, id;
    bit seen;
    req0_data  = 8'hAA;
    req0_valid = 1'b1;
    tick();
    req0_valid = 1'b0;
    tick();
    tick();
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
    checks++;
    if (done_count !== '0) begin errors++; $display("[TB] FAIL abort_done_count: got %0d expected 0", done_count); end
    tick();
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 15; k++) begin
      if (done_valid) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen) begin errors++; $display("[TB] FAIL abort_no_done: got done pulse 1 expected 0"); end
    submit(0, 16'h00A8, rdy, lat, cnt, id);
    checks++;
    if (cnt != 1) begin errors++; $display("[TB] FAIL abort_resubmit_count: got %0d expected 1", cnt); end
    tick();
  endtask

  task automatic test_boundary();
    logic rdy;
    int lat, cnt, id;
    submit(0, 16'h0000, rdy, lat, cnt, id);
    checks++;
    if (cnt != 0) begin errors++; $display("[TB] FAIL boundary_00: got %0d expected 0", cnt); end
    tick();
    submit(1, 16'h00FF, rdy, lat, cnt, id);
    checks++;
    if (cnt != 0) begin errors++; $display("[TB] FAIL boundary_FF: got %0d expected 0", cnt); end
    checks++;
    if (id != 1) begin errors++; $display("[TB] FAIL boundary_FF_id: got %0d expected 1", id); end
    tick();
  endtask

  task automatic test_back_to_back();
    int g_id [4];
    int g_cyc [4];
    int d_id [4];
    int d_cnt [4];
    int d_cyc [4];
    int exp_cnt [4] = '{1, 0, 1, 0};
    int ng, nd;
    bit bad_ready;
    do_reset();
    req0_data  = 8'hA8;
    req1_data  = 8'hFF;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    ng = 0;
    nd = 0;
    bad_ready = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (ng >= 4) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      #1;
      if (busy && (req0_ready || req1_ready)) bad_ready = 1'b1;
      if (req0_ready && req1_ready) bad_ready = 1'b1;
      if ((req0_ready || req1_ready) && ng < 4) begin
        g_id[ng]  = req1_ready ? 1 : 0;
        g_cyc[ng] = c;
        ng++;
      end else if (req0_ready || req1_ready) begin
        ng++;
      end
      if (done_valid && nd < 4) begin
        d_id[nd]  = int'(done_id);
        d_cnt[nd] = int'(done_count);
        d_cyc[nd] = c;
        nd++;
      end
      @(posedge clk);
      #0;
    end
    #1;
    checks++;
    if (bad_ready) begin errors++; $display("[TB] FAIL b2b_ready_while_busy: got 1 expected 0"); end
    checks++;
    if (ng != 4) begin errors++; $display("[TB] FAIL b2b_grant_count: got %0d expected 4", ng); end
    checks++;
    if (nd != 4) begin errors++; $display("[TB] FAIL b2b_done_count: got %0d expected 4", nd); end
    if (ng >= 4 && nd == 4) begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (g_id[i] != i % 2) begin errors++; $display("[TB] FAIL b2b_grant_id[%0d]: got %0d expected %0d", i, g_id[i], i % 2); end
        checks++;
        if (g_cyc[i] != i * (W + 2)) begin errors++; $display("[TB] FAIL b2b_grant_cycle[%0d]: got %0d expected %0d", i, g_cyc[i], i * (W + 2)); end
        checks++;
        if (d_id[i] != i % 2) begin errors++; $display("[TB] FAIL b2b_done_id[%0d]: got %0d expected %0d", i, d_id[i], i % 2); end
        checks++;
        if (d_cnt[i] != exp_cnt[i]) begin errors++; $display("[TB] FAIL b2b_done_cnt[%0d]: got %0d expected %0d", i, d_cnt[i], exp_cnt[i]); end
        checks++;
        if (d_cyc[i] != i * (W + 2) + W + 1) begin errors++; $display("[TB] FAIL b2b_done_cycle[%0d]: got %0d expected %0d", i, d_cyc[i], i * (W + 2) + W + 1); end
      end
    end
    tick();
  endtask

  task automatic test_wide_saturation();
    logic rdy;
    int lat, cnt, id;
    do_reset();
    submit(2, 16'hAAAA, rdy, lat, cnt, id);
    checks++;
    if (lat != W16 + 1) begin errors++; $display("[TB] FAIL wide_latency: got %0d expected %0d", lat, W16 + 1); end
    checks++;
    if (cnt != EXP_WIDE) begin errors++; $display("[TB] FAIL wide_count: got %0d expected %0d", cnt, EXP_WIDE); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_words();
    test_reset_abort();
    test_boundary();
    test_back_to_back();
    test_wide_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
